retire_unit: RTL

RETIRE_UNIT -- requirements
Module: retire_unit

---
 rtl/retire_unit.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/retire_unit.sv
// retire_unit -- in-order commit stage sitting on the head of a reorder buffer.
//
// Purpose:
//   Pops the ROB head when it is ready and turns it into one registered
//   regfile write. Branch mispredicts are latched and issued one cycle later
//   as a registered flush strobe. A halt instruction retires normally and
//   then freezes all commit until reset.
//
// Ports:
//   clock            in   single clock, rising edge
//   reset            in   asynchronous, active-high reset
//   is_empty         in   ROB holds no entries
//   head_instr[31:0] in   instruction at ROB head (opcode [31:27], rd [26:22])
//   head_val[31:0]   in   result value at ROB head
//   head_ready       in   ROB head entry has finished
//   stall            in   regfile write port busy this cycle
//   mispredict       in   one-cycle pulse, younger entries are invalid
//   mispredict_instr in   instruction word of the mispredicted branch
//   pop              out  combinational ROB pop request
//   flushing_instr   out  registered flush strobe
//   instr_to_flush   out  registered flush match word
//   ctrl_writeEnable out  registered regfile write enable
//   ctrl_writeReg    out  registered regfile destination
//   data_writeReg    out  registered regfile write data
//   halted           out  registered, high once the halt instruction retired
//   retire_count     out  retire counter (only with RETIRE_COUNT_EN defined)
//
// Build option:
//   RETIRE_COUNT_EN  adds the 32-bit wrapping retire_count output.

module retire_unit #(
  parameter logic [4:0] HALT_OPCODE = 5'b11111,
  parameter logic [4:0] RA_REG      = 5'd31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        is_empty,
  input  logic [31:0] head_instr,
  input  logic [31:0] head_val,
  input  logic        head_ready,
  input  logic        stall,
  input  logic        mispredict,
  input  logic [31:0] mispredict_instr,
  output logic        pop,
  output logic        flushing_instr,
  output logic [31:0] instr_to_flush,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        halted
`ifdef RETIRE_COUNT_EN
  ,
  output logic [31:0] retire_count
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_JAL   = 5'b00011;
  localparam logic [4:0] OP_SETX  = 5'b10101;
  localparam logic [4:0] SETX_REG = 5'd30;

  state_t      state_reg, state_next;
  logic        pend_valid_reg, pend_valid_next;
  logic [31:0] pend_word_reg, pend_word_next;

  logic        flush_reg;
  logic [31:0] flush_word_reg;
  logic        we_reg;
  logic [4:0]  wreg_reg;
  logic [31:0] wdata_reg;
  logic        halted_reg;

  // ---------------------------------------------------------------------
  // Write decode of the head instruction
  // ---------------------------------------------------------------------
  logic [4:0] head_opcode;
  logic       head_is_nop;
  logic       dec_write;
  logic [4:0] dec_rd;

  assign head_opcode = head_instr[31:27];
  assign head_is_nop = (head_instr == 32'd0);

  always_comb begin
    dec_write = 1'b0;
    dec_rd    = 5'd0;
    if (!head_is_nop) begin
      case (head_opcode)
        OP_RTYPE, OP_ADDI, OP_LW: begin
          dec_write = 1'b1;
          dec_rd    = head_instr[26:22];
        end
        OP_JAL: begin
          dec_write = 1'b1;
          dec_rd    = RA_REG;
        end
        OP_SETX: begin
          dec_write = 1'b1;
          dec_rd    = SETX_REG;
        end
        default: begin
          dec_write = 1'b0;
          dec_rd    = 5'd0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Pop request. Gated by reset so the ROB never sees a pop while the
  // commit stage is being cleared.
  // ---------------------------------------------------------------------
  assign pop = !reset && (state_reg == RUN) && head_ready && !is_empty &&
               !stall && !mispredict && !pend_valid_reg;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    pend_valid_next = pend_valid_reg;
    pend_word_next  = pend_word_reg;
    case (state_reg)
      RUN: begin
        if (mispredict) begin
          pend_valid_next = 1'b1;
          pend_word_next  = mispredict_instr;
          state_next      = FLUSH;
        end else if (pop && (head_opcode == HALT_OPCODE)) begin
          state_next = HALT;
        end
      end
      FLUSH: begin
        // The latch is one deep: a mispredict seen while a flush is being
        // issued replaces the word and buys exactly one more FLUSH cycle.
        if (mispredict) begin
          pend_valid_next = 1'b1;
          pend_word_next  = mispredict_instr;
          state_next      = FLUSH;
        end else begin
          pend_valid_next = 1'b0;
          pend_word_next  = 32'd0;
          state_next      = RUN;
        end
      end
      HALT: begin
        pend_valid_next = 1'b0;
        pend_word_next  = 32'd0;
        state_next      = HALT;
      end
      default: begin
        pend_valid_next = 1'b0;
        pend_word_next  = 32'd0;
        state_next      = RUN;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= RUN;
      pend_valid_reg <= 1'b0;
      pend_word_reg  <= 32'd0;
    end else begin
      state_reg      <= state_next;
      pend_valid_reg <= pend_valid_next;
      pend_word_reg  <= pend_word_next;
    end
  end

  // ---------------------------------------------------------------------
  // Registered outputs. Flush and halt outputs are driven from the next
  // state so they line up with the cycle the FSM spends in that state.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flush_reg      <= 1'b0;
      flush_word_reg <= 32'd0;
      halted_reg     <= 1'b0;
      we_reg         <= 1'b0;
      wreg_reg       <= 5'd0;
      wdata_reg      <= 32'd0;
    end else begin
      flush_reg      <= (state_next == FLUSH);
      flush_word_reg <= (state_next == FLUSH) ? pend_word_next : 32'd0;
      halted_reg     <= (state_next == HALT);
      if (pop) begin
        // A decoded destination of r0 still retires, just without a write.
        we_reg    <= dec_write && (dec_rd != 5'd0);
        wreg_reg  <= dec_rd;
        wdata_reg <= head_val;
      end else begin
        we_reg    <= 1'b0;
        wreg_reg  <= 5'd0;
        wdata_reg <= 32'd0;
      end
    end
  end

  assign flushing_instr   = flush_reg;
  assign instr_to_flush   = flush_word_reg;
  assign ctrl_writeEnable = we_reg;
  assign ctrl_writeReg    = wreg_reg;
  assign data_writeReg    = wdata_reg;
  assign halted           = halted_reg;

`ifdef RETIRE_COUNT_EN
  logic [31:0] count_reg;

  // Natural 32-bit wrap from all-ones back to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= 32'd0;
    end else if (pop) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign retire_count = count_reg;
`endif

endmodule
